// File: rtl/regfile_pkg.sv
// Types and constants shared by the regfile sequencer and the regfile itself.
package regfile_pkg;

  localparam int unsigned NIBBLE_W  = 4;
  localparam int unsigned REG_COUNT = 16;

  // Sequencer states; the encoding is fixed so LEDs and debug taps stay stable.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad1  = 3'd1,
    StWait2  = 3'd2,
    StLoad2  = 3'd3,
    StSettle = 3'd4,
    StExec   = 3'd5,
    StDone   = 3'd6
  } seq_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  // Synchronizer resets high so a button held through reset cannot fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Level follows the synchronized input only after DEB_CYCLES differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == 8'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Debounce state and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Two-press sequencer driving the nibble regfile's load strobes, bus and write
// enable, with a WAIT2 timeout and LED status outputs.
module regfile_seq_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_next,
  input  logic [NIBBLE_W-1:0] sw,
  input  logic                op_write,
  output logic [NIBBLE_W-1:0] no,
  output logic                push1,
  output logic                push2,
  output logic                push3,
  output logic                push4,
  output logic                wenable,
  output logic                busy,
  output logic                read_valid,
  output logic                done,
  output logic                err
);

  logic                press;
  seq_state_e          state_q, state_d;
  logic [NIBBLE_W-1:0] nib_q, nib_d;
  logic                op_q, op_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                err_d;

  logic [NIBBLE_W-1:0] no_q, no_d;
  logic                push1_q, push2_q, push3_q, push4_q;
  logic                push1_d, push2_d, push3_d, push4_d;
  logic                wen_q, wen_d, busy_q, busy_d, rv_q, rv_d, done_q, done_d, err_q;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_next (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_next),
    .press(press)
  );

  // Next-state logic; presses outside IDLE and WAIT2 are simply dropped.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (press) begin
          nib_d   = sw;
          op_d    = op_write;
          state_d = StLoad1;
        end
      end
      StLoad1: begin
        tmo_d   = '0;
        state_d = StWait2;
      end
      StWait2: begin
        tmo_d = tmo_q + 16'd1;
        // A press coinciding with the timeout still completes the transaction.
        if (press) begin
          nib_d   = sw;
          state_d = StLoad2;
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StLoad2:  state_d = StSettle;
      StSettle: state_d = StExec;
      StExec:   state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    no_d    = no_q;
    if (state_d == StLoad1 || state_d == StLoad2) begin
      no_d = nib_d;
    end
    push1_d = (state_d == StLoad1) && !op_d;
    push3_d = (state_d == StLoad1) && op_d;
    push2_d = (state_d == StLoad2) && !op_d;
    push4_d = (state_d == StLoad2) && op_d;
    wen_d   = (state_d == StExec) && op_d;
    rv_d    = (state_d == StExec) && !op_d;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

  // State and registered outputs; reset aborts any transaction with no write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      nib_q   <= '0;
      op_q    <= 1'b0;
      tmo_q   <= '0;
      no_q    <= '0;
      push1_q <= 1'b0;
      push2_q <= 1'b0;
      push3_q <= 1'b0;
      push4_q <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      no_q    <= no_d;
      push1_q <= push1_d;
      push2_q <= push2_d;
      push3_q <= push3_d;
      push4_q <= push4_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign no         = no_q;
  assign push1      = push1_q;
  assign push2      = push2_q;
  assign push3      = push3_q;
  assign push4      = push4_q;
  assign wenable    = wen_q;
  assign busy       = busy_q;
  assign read_valid = rv_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Bench for regfile_seq_ctrl: a behavioural regfile is driven by the DUT and
// compared against an array model of what each transaction should have done.
module tb_regfile_seq_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       btn2 = 1'b0;
  logic       op_write = 1'b0;
  logic [3:0] sw = 4'h0;

  logic [3:0] no, no2;
  logic push1, push2, push3, push4, wenable, busy, read_valid, done, err;
  logic q1, q2, q3, q4, wen2, busy2, rv2, done2, err2;

  int checks = 0;
  int errors = 0;

  regfile_seq_ctrl #(.DEB_CYCLES(DEB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn), .sw(sw), .op_write(op_write),
    .no(no), .push1(push1), .push2(push2), .push3(push3), .push4(push4),
    .wenable(wenable), .busy(busy), .read_valid(read_valid), .done(done), .err(err)
  );

  // Second instance with a 1-cycle debounce so presses can be placed precisely.
  regfile_seq_ctrl #(.DEB_CYCLES(1), .TIMEOUT(TMO)) dut2 (
    .clk(clk), .rst_n(rst_n), .btn_next(btn2), .sw(sw), .op_write(op_write),
    .no(no2), .push1(q1), .push2(q2), .push3(q3), .push4(q4),
    .wenable(wen2), .busy(busy2), .read_valid(rv2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  // Behavioural 16x4 regfile attached to dut (not reset by rst_n).
  logic [3:0] rf_mem [16] = '{default: 4'h0};
  logic [3:0] rf_rr1 = 4'h0, rf_rr2 = 4'h0, rf_wr = 4'h0, rf_wd = 4'h0;
  always @(posedge clk) begin
    if (push1) rf_rr1 <= no;
    if (push2) rf_rr2 <= no;
    if (push3) rf_wr <= no;
    if (push4) rf_wd <= no;
    if (wenable) rf_mem[rf_wr] <= rf_wd;
  end

  // Reference contents: what the regfile should hold after completed writes.
  logic [3:0] ref_mem [16] = '{default: 4'h0};

  // Event log sampled away from the active edge.
  int cyc = 0;
  int n_p1 = 0, n_p2 = 0, n_p3 = 0, n_p4 = 0, n_wen = 0, n_rv = 0, n_done = 0, n_err = 0;
  int c_first = 0, c_second = 0, c_wen = 0, c_rv = 0, c_done = 0, c_err = 0;
  logic [3:0] no_first = 4'h0, no_second = 4'h0, rv_o1 = 4'h0, rv_o2 = 4'h0;
  int viol = 0;
  int n2_push = 0, n2_wen = 0, n2_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (push1) begin n_p1 <= n_p1 + 1; c_first <= cyc; no_first <= no; end
      if (push3) begin n_p3 <= n_p3 + 1; c_first <= cyc; no_first <= no; end
      if (push2) begin n_p2 <= n_p2 + 1; c_second <= cyc; no_second <= no; end
      if (push4) begin n_p4 <= n_p4 + 1; c_second <= cyc; no_second <= no; end
      if (wenable) begin n_wen <= n_wen + 1; c_wen <= cyc; end
      if (read_valid) begin
        n_rv <= n_rv + 1; c_rv <= cyc; rv_o1 <= rf_mem[rf_rr1]; rv_o2 <= rf_mem[rf_rr2];
      end
      if (done) begin n_done <= n_done + 1; c_done <= cyc; end
      if (err) begin n_err <= n_err + 1; c_err <= cyc; end
      if ((32'(push1) + 32'(push2) + 32'(push3) + 32'(push4) > 1) ||
          (wenable && (push1 || push2 || push3 || push4)) || (wenable && !busy))
        viol <= viol + 1;
      if (q1 || q2 || q3 || q4) n2_push <= n2_push + 1;
      if (wen2) n2_wen <= n2_wen + 1;
      if (done2) n2_done <= n2_done + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Press and release btn; lat is negedges from assertion to the load strobe.
  task automatic press1(input logic [3:0] v, output int lat);
    int tot0;
    tot0 = n_p1 + n_p2 + n_p3 + n_p4;
    sw  = v;
    btn = 1'b1;
    lat = 0;
    while ((n_p1 + n_p2 + n_p3 + n_p4) == tot0 && lat < 30) begin
      tick();
      lat++;
    end
    btn = 1'b0;
    repeat (DEB + 4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({no, push1, push2, push3, push4, wenable, busy, read_valid, done, err} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {no, push1, push2, push3, push4, wenable, busy, read_valid, done, err});
    end
    checks++;
    if ({no2, q1, q2, q3, q4, wen2, busy2, rv2, done2, err2} !== 13'h0) begin
      errors++;
      $display("FAIL reset_outputs_dut2: got %h want 0",
               {no2, q1, q2, q3, q4, wen2, busy2, rv2, done2, err2});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (DEB + 6) tick();
    checks++;
    if (busy !== 1'b0 || (n_p1 + n_p2 + n_p3 + n_p4) != 0) begin
      errors++;
      $display("FAIL reset_idle: busy %b pushes %0d want 0 0", busy, n_p1 + n_p2 + n_p3 + n_p4);
    end
  endtask

  task automatic do_txn(input logic op, input logic [3:0] a, input logic [3:0] d,
                        input logic flip, input string name);
    int s1, s2, s3, s4, swen, srv, sdone, lat1, lat2;
    logic [3:0] e1, e2;
    s1 = n_p1; s2 = n_p2; s3 = n_p3; s4 = n_p4; swen = n_wen; srv = n_rv; sdone = n_done;
    e1 = ref_mem[a];
    e2 = ref_mem[d];
    op_write = op;
    press1(a, lat1);
    if (flip) op_write = ~op;
    press1(d, lat2);
    for (int i = 0; i < 20 && n_done == sdone; i++) tick();

    checks++;
    if (lat1 != DEB + 3 || lat2 != DEB + 3) begin
      errors++;
      $display("FAIL %s press_latency: got %0d/%0d want %0d", name, lat1, lat2, DEB + 3);
    end
    checks++;
    if ((op ? (n_p3 - s3) : (n_p1 - s1)) != 1 || (op ? (n_p1 - s1) : (n_p3 - s3)) != 0 ||
        no_first !== a) begin
      errors++;
      $display("FAIL %s first_load: p1 %0d p3 %0d no %h want op %b no %h",
               name, n_p1 - s1, n_p3 - s3, no_first, op, a);
    end
    checks++;
    if ((op ? (n_p4 - s4) : (n_p2 - s2)) != 1 || (op ? (n_p2 - s2) : (n_p4 - s4)) != 0 ||
        no_second !== d) begin
      errors++;
      $display("FAIL %s second_load: p2 %0d p4 %0d no %h want op %b no %h",
               name, n_p2 - s2, n_p4 - s4, no_second, op, d);
    end
    checks++;
    if (n_done - sdone != 1 || c_done != c_second + 3) begin
      errors++;
      $display("FAIL %s done_timing: count %0d at +%0d want 1 at +3",
               name, n_done - sdone, c_done - c_second);
    end
    if (op) begin
      checks++;
      if (n_wen - swen != 1 || c_wen != c_second + 2 || n_rv != srv) begin
        errors++;
        $display("FAIL %s write_commit: wen %0d at +%0d rv %0d want 1 at +2 rv 0",
                 name, n_wen - swen, c_wen - c_second, n_rv - srv);
      end
      ref_mem[a] = d;
    end else begin
      checks++;
      if (n_rv - srv != 1 || c_rv != c_second + 2 || n_wen != swen ||
          rv_o1 !== e1 || rv_o2 !== e2) begin
        errors++;
        $display("FAIL %s read_data: rv %0d at +%0d wen %0d data %h %h want 1 +2 0 %h %h",
                 name, n_rv - srv, c_rv - c_second, n_wen - swen, rv_o1, rv_o2, e1, e2);
      end
    end
  endtask

  task automatic test_write();
    do_txn(1'b1, 4'h5, 4'hA, 1'b0, "write");
  endtask

  task automatic test_readback();
    do_txn(1'b0, 4'h5, 4'h5, 1'b0, "readback");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_bounce();
    int sf, ss, serr;
    sf = n_p1 + n_p3; ss = n_p2 + n_p4; serr = n_err;
    op_write = 1'b0;
    btn = 1'b1; tick();
    btn = 1'b0; tick();
    btn = 1'b1; tick();
    repeat (10) tick();
    btn = 1'b0;
    for (int i = 0; i < TMO + 30 && n_err == serr; i++) tick();
    checks++;
    if ((n_p1 + n_p3) - sf != 1 || (n_p2 + n_p4) != ss) begin
      errors++;
      $display("FAIL bounce_presses: first %0d second %0d want 1 0", (n_p1 + n_p3) - sf,
               (n_p2 + n_p4) - ss);
    end
    checks++;
    if (n_err - serr != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_abort: err %0d busy %b want 1 0", n_err - serr, busy);
    end
  endtask

  task automatic test_timeout();
    int serr, swen, s4, lat, bad;
    serr = n_err; swen = n_wen; s4 = n_p4;
    op_write = 1'b1;
    press1(4'h3, lat);
    for (int i = 0; i < 40 && n_err == serr; i++) tick();
    tick();
    checks++;
    if (n_err - serr != 1 || c_err != c_first + TMO + 1) begin
      errors++;
      $display("FAIL timeout_err: count %0d at +%0d want 1 at +%0d",
               n_err - serr, c_err - c_first, TMO + 1);
    end
    checks++;
    if (n_wen != swen || n_p4 != s4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_no_write: wen %0d p4 %0d busy %b want 0 0 0",
               n_wen - swen, n_p4 - s4, busy);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (rf_mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_contents: %0d registers differ want 0", bad);
    end
  endtask

  task automatic test_reset_midop();
    int swen, s4, tot, lat, i;
    do_txn(1'b1, 4'h3, 4'hC, 1'b0, "pre_reset_write");
    swen = n_wen; s4 = n_p4;
    op_write = 1'b1;
    press1(4'h3, lat);
    sw  = 4'h7;
    btn = 1'b1;
    for (i = 0; i < 30 && n_p4 == s4; i++) tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({no, push1, push2, push3, push4, wenable, busy, read_valid, done, err} !== 13'h0) begin
      errors++;
      $display("FAIL midop_reset_outputs: got %h want 0 (push4 seen %0d)",
               {no, push1, push2, push3, push4, wenable, busy, read_valid, done, err}, n_p4 - s4);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tot = n_p1 + n_p2 + n_p3 + n_p4;
    repeat (20) tick();
    checks++;
    if ((n_p1 + n_p2 + n_p3 + n_p4) != tot || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_button: pushes %0d busy %b want 0 0",
               (n_p1 + n_p2 + n_p3 + n_p4) - tot, busy);
    end
    btn = 1'b0;
    repeat (DEB + 4) tick();
    checks++;
    if (n_wen != swen || rf_mem[3] !== ref_mem[3]) begin
      errors++;
      $display("FAIL midop_no_write: wen %0d reg3 %h want 0 %h", n_wen - swen, rf_mem[3],
               ref_mem[3]);
    end
  endtask

  // Presses on dut2 at raw cycles 0, 8 and 11: address, data, then one landing in EXEC.
  task automatic test_discard();
    int sp, sw2, sd, bc;
    sp = n2_push; sw2 = n2_wen; sd = n2_done; bc = 0;
    op_write = 1'b1;
    for (int k = 0; k < 40; k++) begin
      btn2 = (k == 0 || k == 1 || k == 8 || k == 9 || k == 11);
      sw   = (k < 6) ? 4'h2 : 4'h9;
      tick();
      if (k >= 25 && busy2) bc++;
    end
    btn2 = 1'b0;
    checks++;
    if (n2_push - sp != 2 || n2_wen - sw2 != 1 || n2_done - sd != 1) begin
      errors++;
      $display("FAIL discard_txn: pushes %0d wen %0d done %0d want 2 1 1",
               n2_push - sp, n2_wen - sw2, n2_done - sd);
    end
    checks++;
    if (bc != 0) begin
      errors++;
      $display("FAIL discard_busy: busy cycles %0d after done want 0", bc);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL strobe_exclusive: %0d violating cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_bounce();
    test_timeout();
    test_random();
    test_reset_midop();
    test_discard();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
